// File: rtl/rissy_pkg.sv
// Shared ISA definitions: op classes, 4-bit opcodes, field positions, encoder helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rissy_pkg;

  // Op classes as presented on the encoder's in_op port; 6 and 7 are illegal
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_NDU = 3'd1,
    OP_LW  = 3'd2,
    OP_SW  = 3'd3,
    OP_BEQ = 3'd4,
    OP_JAL = 3'd5
  } op_class_e;

  // 4-bit opcodes placed in the top nibble of the instruction word
  localparam logic [3:0] OPC_ADD = 4'h0;
  localparam logic [3:0] OPC_NDU = 4'h2;
  localparam logic [3:0] OPC_LW  = 4'h4;
  localparam logic [3:0] OPC_SW  = 4'h5;
  localparam logic [3:0] OPC_BEQ = 4'hC;
  localparam logic [3:0] OPC_JAL = 4'h8;

  // Field positions inside a 16-bit instruction word
  localparam int INST_W  = 16;
  localparam int OPC_LSB = 12;
  localparam int RA_LSB  = 9;
  localparam int RB_LSB  = 6;
  localparam int RC_LSB  = 3;
  localparam int IMM_W   = 6;

  typedef struct packed {
    logic              legal;
    logic [INST_W-1:0] word;
  } enc_t;

  // Builds the instruction word and flags bundles that cannot be encoded
  function automatic enc_t encode_inst(input logic [2:0]  op,
                                       input logic [2:0]  ra,
                                       input logic [2:0]  rb,
                                       input logic [2:0]  rc,
                                       input logic [15:0] imm);
    enc_t       r;
    logic [3:0] opc;
    logic       imm_fmt;
    r       = '0;
    opc     = '0;
    imm_fmt = 1'b1;
    r.legal = 1'b1;
    case (op)
      OP_ADD:  begin opc = OPC_ADD; imm_fmt = 1'b0; end
      OP_NDU:  begin opc = OPC_NDU; imm_fmt = 1'b0; end
      OP_LW:   opc = OPC_LW;
      OP_SW:   opc = OPC_SW;
      OP_BEQ:  opc = OPC_BEQ;
      OP_JAL:  opc = OPC_JAL;
      default: r.legal = 1'b0;
    endcase
    // Immediates wider than the 6-bit field are not silently truncated
    if (imm_fmt && (imm[15:IMM_W] != '0)) r.legal = 1'b0;
    r.word[OPC_LSB +: 4] = opc;
    r.word[RA_LSB +: 3]  = ra;
    r.word[RB_LSB +: 3]  = rb;
    if (imm_fmt) r.word[IMM_W-1:0] = imm[IMM_W-1:0];
    else         r.word[RC_LSB +: 3] = rc;
    return r;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO for encoded words, count-based full/empty.
// Latency: a pushed word is visible on rd_data the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; no bypass.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 wr_data,
  input  logic                         pop,
  output logic [W-1:0]                 rd_data,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Control state; reset empties the buffer by clearing pointers and count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;

endmodule

// File: rtl/inst_encoder.sv
// Encodes instruction field bundles and streams the words into instruction memory.
// Latency: a word accepted in cycle N is presented with mem_we in cycle N+1.
// Backpressure: in_ready drops when the buffer is full; mem_ready=0 holds the write stable.
module inst_encoder
  import rissy_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [2:0]        in_ra,
  input  logic [2:0]        in_rb,
  input  logic [2:0]        in_rc,
  input  logic [15:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_e;

  enc_t              enc;
  logic              accept, push, reject, pop;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [INST_W-1:0] fifo_head;

  state_e            state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              err_q, err_d;

  // A pop in the same cycle never frees a slot early: full is from registered count
  assign in_ready = !rst && !fifo_full;

  // Handshake, encode and drop decision for the incoming bundle
  always_comb begin
    enc    = encode_inst(in_op, in_ra, in_rb, in_rc, in_imm);
    accept = in_valid && in_ready;
    push   = accept && enc.legal;
    reject = accept && !enc.legal;
    pop    = mem_we_q && mem_ready;
  end

  inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (INST_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (enc.word),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  // Next state: ACTIVE exactly while the buffer holds at least one word
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (push) state_d = S_ACTIVE;
      S_ACTIVE: if (pop && !push && (fifo_count == CNT_W'(1))) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    mem_we_d = (state_d == S_ACTIVE);
  end

  // FSM state and registered write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mem_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= mem_we_d;
    end
  end

  // Write address advances per completed write; reloads only when nothing is in flight
  always_comb begin
    mem_addr_d = mem_addr_q;
    if (pop) mem_addr_d = mem_addr_q + 1'b1;
    else if (addr_load && (state_q == S_IDLE) && !push) mem_addr_d = addr_base;
    err_d = err_q;
    if (reject)       err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  // Address and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      err_q      <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_we_q ? fifo_head : '0;
  assign err       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench: driver models each accepted bundle, monitor checks memory writes.
// Latency: expected words become checkable the cycle after acceptance.
// Backpressure: mem_ready stalls are randomised and checked for output stability.
module tb_inst_encoder;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op, in_ra, in_rb, in_rc;
  logic [15:0] in_imm;
  logic        addr_load;
  logic [15:0] addr_base;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic        err;
  logic        err_clr;

  inst_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_imm(in_imm),
    .addr_load(addr_load), .addr_base(addr_base),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] next_addr;   // address the next accepted word will be written to
  logic        exp_err;
  bit          last_acc;
  bit          mon_popped;
  bit          tb_done, mon_done;
  int          n_vec, n_mis;

  // Reference: opcode nibble at weight 4096, ra 512, rb 64, rc 8 or raw 6-bit imm
  function automatic int ref_word(int op, int ra, int rb, int rc, int imm);
    int opc;
    case (op)
      0: opc = 0;
      1: opc = 2;
      2: opc = 4;
      3: opc = 5;
      4: opc = 12;
      default: opc = 8;
    endcase
    if (op < 2) return opc * 4096 + ra * 512 + rb * 64 + rc * 8;
    return opc * 4096 + ra * 512 + rb * 64 + imm;
  endfunction

  function automatic bit ref_legal(int op, int imm);
    return (op <= 5) && ((op < 2) || (imm < 64));
  endfunction

  // One clock of stimulus: inputs already driven; model the upcoming edge, then advance
  task automatic tick();
    bit   acc, leg, idle;
    exp_t e;
    #6;
    if (rst) begin
      exp_q.delete();
      next_addr = 16'h0000;
      exp_err   = 1'b0;
      last_acc  = 1'b0;
    end else begin
      leg  = ref_legal(int'(in_op), int'(in_imm));
      acc  = in_valid && in_ready;
      idle = (exp_q.size() == 0) && !mon_popped;
      last_acc = acc;
      if (acc && leg) begin
        e.addr = next_addr;
        e.data = 16'(ref_word(int'(in_op), int'(in_ra), int'(in_rb), int'(in_rc), int'(in_imm)));
        exp_q.push_back(e);
        next_addr = next_addr + 16'd1;
      end else if (addr_load && idle) begin
        next_addr = addr_base;
      end
      if (acc && !leg) exp_err = 1'b1;
      else if (err_clr) exp_err = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int op, int ra, int rb, int rc, int imm, bit mr, bit clr);
    in_valid  = v;
    in_op     = 3'(op);
    in_ra     = 3'(ra);
    in_rb     = 3'(rb);
    in_rc     = 3'(rc);
    in_imm    = 16'(imm);
    mem_ready = mr;
    err_clr   = clr;
    addr_load = 1'b0;
    tick();
  endtask

  task automatic idle(int n, bit mr);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, mr, 0);
  endtask

  task automatic load_addr(logic [15:0] base, bit mr);
    in_valid  = 1'b0;
    mem_ready = mr;
    err_clr   = 1'b0;
    addr_load = 1'b1;
    addr_base = base;
    tick();
    addr_load = 1'b0;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT state against the scoreboard away from the active edge
  bit          prev_stall;
  logic [15:0] prev_addr, prev_data;
  always @(negedge clk) begin
    int occ;
    mon_popped = 1'b0;
    if (rst) begin
      chk("in_ready_in_reset", int'(in_ready), 0);
      prev_stall = 1'b0;
    end else begin
      occ = exp_q.size();
      chk("in_ready", int'(in_ready), (occ < DEPTH) ? 1 : 0);
      chk("mem_we", int'(mem_we), (occ > 0) ? 1 : 0);
      chk("err", int'(err), int'(exp_err));
      if (prev_stall) begin
        chk("hold_addr", int'(mem_addr), int'(prev_addr));
        chk("hold_data", int'(mem_wdata), int'(prev_data));
      end
      if (occ == 0) begin
        chk("idle_addr", int'(mem_addr), int'(next_addr));
        chk("idle_wdata", int'(mem_wdata), 0);
      end else begin
        chk("wr_addr", int'(mem_addr), int'(exp_q[0].addr));
        chk("wr_data", int'(mem_wdata), int'(exp_q[0].data));
        if (mem_we && mem_ready) begin
          void'(exp_q.pop_front());
          mon_popped = 1'b1;
        end
      end
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
    end
    if (tb_done && !mon_done) begin
      chk("drained", exp_q.size(), 0);
      mon_done = 1'b1;
    end
  end

  initial begin
    int idx;
    n_vec = 0; n_mis = 0;
    tb_done = 0; mon_done = 0; mon_popped = 0; prev_stall = 0;
    next_addr = 16'h0000; exp_err = 1'b0;
    rst = 1'b1; in_valid = 0; in_op = 0; in_ra = 0; in_rb = 0; in_rc = 0; in_imm = 0;
    addr_load = 0; addr_base = 0; mem_ready = 1; err_clr = 0;
    @(posedge clk);
    #1;
    idle(2, 1);
    rst = 1'b0;
    idle(1, 1);

    // ADD into base 0x0010
    load_addr(16'h0010, 1);
    drive(1, 0, 1, 2, 3, 0, 1, 0);
    idle(2, 1);

    // LW then BEQ back to back
    drive(1, 2, 5, 1, 0, 'h2A, 1, 0);
    drive(1, 4, 7, 7, 0, 'h3F, 1, 0);
    idle(3, 1);

    // Rejections: oversized immediate, illegal op, clear racing a rejection
    drive(1, 3, 1, 1, 0, 'h40, 1, 0);
    drive(1, 6, 2, 2, 2, 0, 1, 0);
    idle(2, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    idle(1, 1);
    drive(1, 7, 0, 0, 0, 0, 1, 1);
    idle(1, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    idle(1, 1);

    // Fill under a stalled memory, try a load while busy, then drain
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1, 1, idx, idx + 1, idx + 2, 0, 0, 0);
      if (last_acc) idx++;
    end
    load_addr(16'h1234, 0);
    for (int c = 0; c < 20 && idx < 5; c++) begin
      drive(1, 1, idx, idx + 1, idx + 2, 0, 1, 0);
      if (last_acc) idx++;
    end
    idle(8, 1);

    // Address wrap at all-ones
    load_addr(16'hFFFF, 1);
    drive(1, 5, 3, 4, 0, 'h11, 1, 0);
    drive(1, 0, 6, 5, 4, 0, 1, 0);
    idle(4, 1);

    // Reset with words buffered
    drive(1, 2, 1, 1, 0, 1, 0, 0);
    drive(1, 2, 2, 2, 0, 2, 0, 0);
    drive(1, 2, 3, 3, 0, 3, 0, 0);
    rst = 1'b1;
    idle(1, 1);
    rst = 1'b0;
    idle(3, 1);

    // Randomised traffic
    for (int c = 0; c < 800; c++) begin
      int op, imm;
      op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
      imm = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 63));
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 11) == 0) begin
        addr_base = 16'($urandom);
        addr_load = 1'b1;
      end else begin
        addr_load = 1'b0;
      end
      in_valid  = ($urandom_range(0, 1) == 1);
      in_op     = 3'(op);
      in_ra     = 3'($urandom);
      in_rb     = 3'($urandom);
      in_rc     = 3'($urandom);
      in_imm    = 16'(imm);
      mem_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst = 1'b0;
    addr_load = 1'b0;

    for (int c = 0; c < 60 && exp_q.size() != 0; c++) idle(1, 1);
    idle(2, 1);
    tb_done = 1'b1;
    for (int c = 0; c < 5 && !mon_done; c++) idle(1, 1);
    if (!mon_done) $fatal(1, "FAIL monitor_end: monitor never reported");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
